pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Stage-sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). It consumes the decoded ID-stage opcode, EX-stage hazard information and the data-memory handshake. From these it drives the PC and pipeline-register write enables and flushes, freezes the pipeline on memory wait, and drains the pipeline in an orderly way on HALT. It also keeps saturating stall and flush performance counters.

Parameters:
DRAIN_CYCLES, 3, cycles spent in DRAIN after HALT leaves ID (EX+MEM+WB of older instructions)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_opcode  in  7  opcode of instruction in IF/ID
id_rs1  in  5  rs1 field in IF/ID
id_rs2  in  5  rs2 field in IF/ID
ex_mem_read  in  1  instruction in ID/EX is a load
ex_rd  in  5  destination of instruction in ID/EX
ex_redirect  in  1  taken branch / JAL / JALR resolved in EX
mem_req  in  1  MEM stage holds a valid load/store
mem_ack  in  1  data memory completes access this cycle
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads bubble
idex_flush  out  1  ID/EX loads bubble
freeze  out  1  hold ID/EX, EX/MEM, MEM/WB (and PC, IF/ID)
halted  out  1  registered; core stopped
stall_cycles  out  CNT_W  saturating count of stall/freeze cycles
flush_count  out  CNT_W  saturating count of redirects

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- State machine: RUN, DRAIN, HALTED. Reset gives RUN, drain counter = DRAIN_CYCLES, halted=0, both counters 0.
- While reset is high, outputs are pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, freeze=0, halted=0.
- mem_wait = mem_req & ~mem_ack.
- rs1 use: opcodes R, I, LOAD, STORE, BRANCH, JALR.
- rs2 use: opcodes R, STORE, BRANCH.
- JAL, HALT and unknown opcodes use neither source register.
- load_use = ex_mem_read & ex_rd!=0 & ((use_rs1 & ex_rd==id_rs1) | (use_rs2 & ex_rd==id_rs2)).
- RUN outputs are combinational, in priority order:
  1. mem_wait: freeze=1, pc_write=0, ifid_write=0, no flushes. Redirect, load_use and halt are ignored this cycle; the inputs are held, so they re-present next cycle.
  2. ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. This overrides load_use and halt, because the ID instruction is wrong-path.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1 (one bubble). The condition clears naturally the next cycle.
  4. id_opcode==HALT (7'b1111111): pc_write=0, ifid_write=0, idex_flush=1. Next state is DRAIN with the counter loaded to DRAIN_CYCLES.
  5. Otherwise: pc_write=1, ifid_write=1, all flushes and freeze 0.
- DRAIN:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1. ex_redirect is ignored (EX holds only bubbles).
  - If mem_wait: freeze=1 and the counter holds.
  - Else the counter decrements. When it is 1 and decrements, the next state is HALTED.
- HALTED: pc_write=0, ifid_write=0, freeze=1, halted=1. This state is sticky until reset.
- Counter rules:
  - stall_cycles increments in any RUN or DRAIN cycle with mem_wait, or in RUN with load_use selected (priority 3).
  - flush_count increments on each RUN cycle where priority 2 is selected.
  - Both counters saturate at all-ones, do not wrap, and are frozen in HALTED.
- Reset asserted mid-DRAIN or in HALTED returns to RUN next edge with counters cleared.
- Latency: all control outputs are same-cycle combinational, except halted (registered) and the counters (registered).

Decomposition:
- riscv_pkg: opcode_t enum (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, HALT 1111111), shared with the main decoder.
- riscv_pkg also holds ctrl_state_t {RUN, DRAIN, HALTED}.
- One combinational sub-module, load_use_detect: inputs id_opcode, id_rs1, id_rs2, ex_mem_read, ex_rd; output load_use.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_opcode=R, id_rs2=5 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles 0->1. Repeating with ex_rd=0 gives no stall.
2. Redirect vs load-use: ex_redirect=1 with a load_use condition also true -> ifid_flush=1, idex_flush=1, pc_write=1; flush_count=1; stall_cycles unchanged.
3. Memory wait: mem_req=1, mem_ack=0 for 4 cycles with ex_redirect=1 -> freeze=1, no flush for 4 cycles; stall_cycles=4. On ack, the redirect is taken (flush_count=1).
4. Halt drain: HALT in ID, no hazards -> DRAIN for 3 cycles; halted rises on the 4th edge after entry. A mem_wait of 2 cycles in DRAIN delays halted by exactly 2.
5. Reset mid-DRAIN: assert reset for 1 cycle during DRAIN -> next cycle state RUN, halted=0, counters 0, pc_write=1 with idle inputs.
6. Saturation (CNT_W=4): 20 consecutive load_use stalls -> stall_cycles stops at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 definitions for the pipeline controller and the main decoder.
//   opcode_t     : base opcodes recognised by the pipeline, plus the custom
//                  HALT encoding (all ones).
//   ctrl_state_t : sequencing states of pipeline_ctrl.
//   uses_rs1/2   : which source registers an opcode actually reads. These
//                  decide whether a load in EX can hazard the ID instruction.
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_HALT   = 7'b1111111
  } opcode_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } ctrl_state_t;

  // JAL, HALT and unknown opcodes read no source register.
  function automatic logic uses_rs1(input logic [6:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: r = 1'b1;
      default:                                           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_R, OP_STORE, OP_BRANCH: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector.
//   id_opcode   in  7  opcode of the instruction in IF/ID
//   id_rs1      in  5  rs1 field in IF/ID
//   id_rs2      in  5  rs2 field in IF/ID
//   ex_mem_read in  1  instruction in ID/EX is a load
//   ex_rd       in  5  destination register of the ID/EX instruction
//   load_use    out 1  ID instruction needs the load result not yet available
// ---------------------------------------------------------------------------
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic w_use_rs1;
  logic w_use_rs2;
  logic w_hit_rs1;
  logic w_hit_rs2;

  always_comb begin
    w_use_rs1 = uses_rs1(id_opcode);
    w_use_rs2 = uses_rs2(id_opcode);
    w_hit_rs1 = w_use_rs1 && (ex_rd == id_rs1);
    w_hit_rs2 = w_use_rs2 && (ex_rd == id_rs2);
    // x0 is never a real producer, so a load to x0 cannot hazard.
    load_use  = ex_mem_read && (ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stage-sequencing controller for the 5-stage RV32 pipeline.
// Parameters:
//   DRAIN_CYCLES  cycles spent draining EX/MEM/WB after HALT leaves ID
//   CNT_W         width of the saturating performance counters
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   id_opcode/id_rs1/id_rs2 instruction fields in IF/ID
//   ex_mem_read, ex_rd      load information for the ID/EX instruction
//   ex_redirect             taken branch / JAL / JALR resolved in EX
//   mem_req, mem_ack        data-memory handshake of the MEM stage
//   pc_write, ifid_write    PC and IF/ID enables            (combinational)
//   ifid_flush, idex_flush  bubble insertion                (combinational)
//   freeze                  hold the whole pipeline         (combinational)
//   halted                  core stopped                    (registered)
//   stall_cycles            saturating stall/freeze cycle count
//   flush_count             saturating redirect count
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t       r_state;
  logic [DCNT_W-1:0] r_drain_cnt;
  logic              r_halted;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_count;

  logic w_mem_wait;
  logic w_load_use;
  logic w_redirect_take;
  logic w_halt_take;
  logic w_stall_inc;

  load_use_detect u_load_use_detect (
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (w_load_use)
  );

  assign w_mem_wait = mem_req && !mem_ack;

  // Control outputs plus the "which RUN priority won" strobes that drive the
  // FSM and counters, so both always see the same selection.
  always_comb begin
    pc_write        = 1'b0;
    ifid_write      = 1'b0;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    freeze          = 1'b0;
    w_redirect_take = 1'b0;
    w_halt_take     = 1'b0;
    w_stall_inc     = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_wait) begin
            freeze      = 1'b1;
            w_stall_inc = 1'b1;
          end else if (ex_redirect) begin
            pc_write        = 1'b1;
            ifid_write      = 1'b1;
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
            w_redirect_take = 1'b1;
          end else if (w_load_use) begin
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
          end else if (id_opcode == OP_HALT) begin
            idex_flush  = 1'b1;
            w_halt_take = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        DRAIN: begin
          idex_flush = 1'b1;
          if (w_mem_wait) begin
            freeze      = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
        HALTED: begin
          freeze = 1'b1;
        end
        default: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= RUN;
      r_drain_cnt    <= DCNT_W'(DRAIN_CYCLES);
      r_halted       <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_halt_take) begin
            r_state     <= DRAIN;
            r_drain_cnt <= DCNT_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (!w_mem_wait) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
            if (r_drain_cnt == DCNT_W'(1)) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase

      // Strobes are only ever raised in RUN/DRAIN, so HALTED freezes counts.
      if (w_stall_inc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_redirect_take && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  // halted is registered but must read low for the whole reset cycle, even
  // when reset arrives while the core is already HALTED.
  assign halted       = r_halted && !reset;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned CW = 4;

  localparam logic [6:0] C_R     = 7'b0110011;
  localparam logic [6:0] C_I     = 7'b0010011;
  localparam logic [6:0] C_STORE = 7'b0100011;
  localparam logic [6:0] C_JAL   = 7'b1101111;
  localparam logic [6:0] C_HALT  = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    id_opcode;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic          ex_mem_read;
  logic [4:0]    ex_rd;
  logic          ex_redirect;
  logic          mem_req;
  logic          mem_ack;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_flush;
  logic          freeze;
  logic          halted;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    string         name;
    logic [5:0]    ctl;   // {pc_write, ifid_write, ifid_flush, idex_flush, freeze, halted}
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
  } exp_t;

  exp_t sb[$];

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .freeze       (freeze),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  // Monitor: the DUT presents a full control word every cycle; compare it
  // mid-cycle against the oldest queued expectation.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_write, ifid_write, ifid_flush, idex_flush, freeze, halted};
        n_tests++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL %s ctl: got %b expected %b (pw iw iff idf frz hlt)", e.name, act, e.ctl);
        end
        n_tests++;
        if (stall_cycles !== e.st) begin
          n_fail++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.st);
        end
        n_tests++;
        if (flush_count !== e.fl) begin
          n_fail++;
          $display("FAIL %s flush_count: got %0d expected %0d", e.name, flush_count, e.fl);
        end
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic [6:0] op,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic mr, input logic [4:0] rd, input logic redir,
                      input logic req, input logic ack,
                      input logic [5:0] ctl, input int st, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    id_opcode   = op;
    id_rs1      = rs1;
    id_rs2      = rs2;
    ex_mem_read = mr;
    ex_rd       = rd;
    ex_redirect = redir;
    mem_req     = req;
    mem_ack     = ack;
    e.name = name;
    e.ctl  = ctl;
    e.st   = CW'(st);
    e.fl   = CW'(fl);
    sb.push_back(e);
  endtask

  // Common control words {pw iw iff idf frz hlt}
  localparam logic [5:0] K_RST   = 6'b001100;
  localparam logic [5:0] K_GO    = 6'b110000;
  localparam logic [5:0] K_BUB   = 6'b000100;
  localparam logic [5:0] K_REDIR = 6'b111100;
  localparam logic [5:0] K_FRZ   = 6'b000010;
  localparam logic [5:0] K_DFRZ  = 6'b000110;
  localparam logic [5:0] K_HALT  = 6'b000011;

  initial begin
    reset = 1'b1; id_opcode = C_I; id_rs1 = 5'd1; id_rs2 = 5'd2;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

    step("reset",        1, C_I, 1, 2, 0, 0, 0, 0, 0, K_RST, 0, 0);
    step("idle",         0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,  0, 0);

    // Load-use
    step("lu_r_rs2",     0, C_R, 1, 5, 1, 5, 0, 0, 0, K_BUB, 0, 0);
    step("lu_after",     0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,  1, 0);
    step("lu_rd0",       0, C_R, 1, 0, 1, 0, 0, 0, 0, K_GO,  1, 0);
    step("lu_i_rs2",     0, C_I, 1, 5, 1, 5, 0, 0, 0, K_GO,  1, 0);
    step("lu_jal_rs1",   0, C_JAL, 5, 5, 1, 5, 0, 0, 0, K_GO, 1, 0);
    step("lu_store_rs2", 0, C_STORE, 3, 7, 1, 7, 0, 0, 0, K_BUB, 1, 0);
    step("lu_store_aft", 0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,  2, 0);

    // Redirect overrides load-use
    step("redir_lu",     0, C_R, 1, 5, 1, 5, 1, 0, 0, K_REDIR, 2, 0);
    step("redir_after",  0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,    2, 1);

    // Memory wait holds a pending redirect
    step("mw1",          0, C_I, 1, 2, 0, 0, 1, 1, 0, K_FRZ,   2, 1);
    step("mw2",          0, C_I, 1, 2, 0, 0, 1, 1, 0, K_FRZ,   3, 1);
    step("mw3",          0, C_I, 1, 2, 0, 0, 1, 1, 0, K_FRZ,   4, 1);
    step("mw4",          0, C_I, 1, 2, 0, 0, 1, 1, 0, K_FRZ,   5, 1);
    step("mw_ack_redir", 0, C_I, 1, 2, 0, 0, 1, 1, 1, K_REDIR, 6, 1);
    step("mw_after",     0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,    6, 2);
    step("reset2",       1, C_I, 1, 2, 0, 0, 0, 0, 0, K_RST,   6, 2);
    step("reset2_after", 0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,    0, 0);

    // Halt drain with a 2-cycle memory wait in DRAIN
    step("halt_id",      0, C_HALT, 0, 0, 0, 0, 0, 0, 0, K_BUB,  0, 0);
    step("drain1_redir", 0, C_I, 1, 2, 0, 0, 1, 0, 0, K_BUB,  0, 0);
    step("drain_mw1",    0, C_I, 1, 2, 0, 0, 0, 1, 0, K_DFRZ, 0, 0);
    step("drain_mw2",    0, C_I, 1, 2, 0, 0, 0, 1, 0, K_DFRZ, 1, 0);
    step("drain2",       0, C_I, 1, 2, 0, 0, 0, 0, 0, K_BUB,  2, 0);
    step("drain3",       0, C_I, 1, 2, 0, 0, 0, 0, 0, K_BUB,  2, 0);
    step("halted1",      0, C_R, 1, 5, 1, 5, 0, 1, 0, K_HALT, 2, 0);
    step("halted2",      0, C_I, 1, 2, 0, 0, 1, 0, 0, K_HALT, 2, 0);
    step("halted3",      0, C_I, 1, 2, 0, 0, 0, 0, 0, K_HALT, 2, 0);
    step("reset_halted", 1, C_I, 1, 2, 0, 0, 0, 0, 0, K_RST,  2, 0);
    step("after_rst_h",  0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,   0, 0);

    // Reset mid-DRAIN
    step("pre_lu",       0, C_R, 5, 1, 1, 5, 0, 0, 0, K_BUB,  0, 0);
    step("halt_id2",     0, C_HALT, 0, 0, 0, 0, 0, 0, 0, K_BUB, 1, 0);
    step("drain_a",      0, C_I, 1, 2, 0, 0, 0, 0, 0, K_BUB,  1, 0);
    step("reset_drain",  1, C_I, 1, 2, 0, 0, 0, 0, 0, K_RST,  1, 0);
    step("after_rst_d",  0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,   0, 0);
    step("run_again",    0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,   0, 0);

    // Saturation of a 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      step("sat_lu", 0, C_R, 9, 3, 1, 9, 0, 0, 0, K_BUB, (i < 15) ? i : 15, 0);
    end
    step("sat_after",    0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,   15, 0);
    step("sat_hold",     0, C_I, 1, 2, 0, 0, 0, 0, 0, K_GO,   15, 0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
